// File: rtl/bf_pkg.sv
// Shared definitions for the bilateral-filter normalisation stage.
//   TAPS/PW/WW/OW : window size and the widths of the product, weight and output beats
//   AW/SW         : widths of the product and weight accumulators
//   state_t       : handshake FSM states of bf_norm_div
package bf_pkg;

    localparam int TAPS = 121;  // beats per 11x11 window
    localparam int PW   = 22;   // product beat width
    localparam int WW   = 14;   // weight beat width
    localparam int OW   = 8;    // pixel width and number of divider iterations

    // Seven guard bits: 121 < 2^7, so a full window of maximum beats cannot overflow.
    localparam int AW = PW + 7;
    localparam int SW = WW + 7;
    localparam int CW = 7;

    localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);

    typedef enum logic [1:0] {
        ACC = 2'd0,
        DIV = 2'd1,
        OUT = 2'd2
    } state_t;

endpackage

// File: rtl/bf_seq_div.sv
// Serial restoring divider: one quotient bit per clock, MSB first.
//   clk, rst_n : clock and synchronous active-low reset
//   start      : one-cycle request; n and d are sampled this cycle and bit OW-1 resolves at its edge
//   n          : dividend (AW+1 bits), d : divisor (SW bits)
//   busy       : iterations 2..OW are in progress
//   done       : high in the cycle whose edge resolves the last bit; q is valid in that same cycle
//   q          : quotient, forced to 0 for d==0 and to all-ones when n >= d<<OW
// Latency is OW cycles from start whatever the operands, including the forced cases.
module bf_seq_div
    import bf_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   n,
    input  logic [SW-1:0] d,
    output logic          busy,
    output logic          done,
    output logic [OW-1:0] q
);

    logic [AW:0]   rem;
    logic [SW-1:0] dvs;
    logic [OW-1:0] quo;
    logic [2:0]    step;
    logic          frc;
    logic [OW-1:0] frc_val;

    logic [AW:0]   r_cur;
    logic [SW-1:0] d_cur;
    logic [OW-1:0] q_cur;
    logic [2:0]    k;
    logic [AW:0]   trial;
    logic          take;
    logic [AW:0]   r_nxt;
    logic [OW-1:0] q_nxt;
    logic          sat;

    // The start cycle works straight from the operands so that the whole
    // division fits in OW cycles with no separate load cycle.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        r_cur = rem;
        d_cur = dvs;
        q_cur = quo;
        k     = step;
        if (start) begin
            r_cur = n;
            d_cur = d;
            q_cur = '0;
            k     = 3'(OW - 1);
        end
        trial = {{(AW + 1 - SW){1'b0}}, d_cur} << k;
        take  = (r_cur >= trial);
        r_nxt = take ? (r_cur - trial) : r_cur;
        q_nxt = q_cur;
        if (take) begin
            q_nxt[k] = 1'b1;
        end
    end

    // A quotient of OW+1 or more bits cannot be represented, so clamp it.
    assign sat  = (n >= ({{(AW + 1 - SW){1'b0}}, d} << OW));
    assign done = busy && (step == 3'd0);
    assign q    = frc ? frc_val : q_nxt;

    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            rem     <= '0;
            dvs     <= '0;
            quo     <= '0;
            step    <= '0;
            frc     <= 1'b0;
            frc_val <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            rem     <= r_nxt;
            dvs     <= d;
            quo     <= q_nxt;
            step    <= 3'(OW - 2);
            frc     <= (d == '0) || sat;
            frc_val <= (d == '0) ? '0 : '1;
        end else if (busy) begin
            rem  <= r_nxt;
            quo  <= q_nxt;
            step <= step - 3'd1;
            if (step == 3'd0) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bf_norm_div.sv
// Normalisation stage of the bilateral filter.
// Accumulates TAPS (weight, product) beats, then divides sum(w*I) by sum(w)
// with round-half-up and saturation, and presents the pixel on a valid/ready output.
//   clk, rst_n          : clock and synchronous active-low reset
//   in_valid/in_ready   : input beat handshake; in_prod = w*I, in_wgt = w
//   out_valid/out_ready : output handshake; out_pixel held while stalled
//   busy                : high while dividing or holding a result
module bf_norm_div
    import bf_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    input  logic [WW-1:0] in_wgt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_pixel,
    output logic          busy
);

    state_t        state;
    logic [AW-1:0] psum;
    logic [SW-1:0] wsum;
    logic [CW-1:0] cnt;

    logic [AW:0]   n_val;
    logic          div_start;
    logic          div_busy;
    logic          div_done;
    logic [OW-1:0] div_q;

    // Adding half the divisor turns the truncating divide into round-half-up.
    assign n_val     = {1'b0, psum} + {{(AW + 1 - SW){1'b0}}, wsum >> 1};
    assign div_start = (state == DIV) && !div_busy && !div_done;

    bf_seq_div u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .n     (n_val),
        .d     (wsum),
        .busy  (div_busy),
        .done  (div_done),
        .q     (div_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_pixel <= '0;
            busy      <= 1'b0;
            psum      <= '0;
            wsum      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (in_valid && in_ready) begin
                        psum <= psum + {{(AW - PW){1'b0}}, in_prod};
                        wsum <= wsum + {{(SW - WW){1'b0}}, in_wgt};
                        if (cnt == LAST_TAP) begin
                            cnt      <= '0;
                            state    <= DIV;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DIV: begin
                    // The sums stay frozen here; the divider reads them on its start cycle.
                    if (div_done) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_pixel <= div_q;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= ACC;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        psum      <= '0;
                        wsum      <= '0;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_norm_div.sv
// Self-checking bench for bf_norm_div: directed vector table, bubble/backpressure,
// reset corner cases and random windows against an arithmetic reference model.
module tb_bf_norm_div;
    import bf_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_prod;
    logic [WW-1:0] in_wgt;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_pixel;
    logic          busy;

    bf_norm_div dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_wgt    (in_wgt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WW-1:0] win_w [TAPS];
    logic [PW-1:0] win_p [TAPS];

    typedef struct {
        string name;
        int    w0;
        int    p0;
        int    wr;
        int    pr;
        int    exp_pix;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: rounded weighted mean, clamped to the pixel range, 0 for zero weight.
    function automatic longint model_pixel();
        longint ps = 0;
        longint ws = 0;
        longint qq;
        for (int i = 0; i < TAPS; i++) begin
            ps += longint'(win_p[i]);
            ws += longint'(win_w[i]);
        end
        if (ws == 0) return 0;
        qq = (ps + ws / 2) / ws;
        return (qq > 255) ? 255 : qq;
    endfunction

    task automatic fill_uniform(input int w0, input int p0, input int wr, input int pr);
        for (int i = 0; i < TAPS; i++) begin
            win_w[i] = (i == 0) ? WW'(w0) : WW'(wr);
            win_p[i] = (i == 0) ? PW'(p0) : PW'(pr);
        end
    endtask

    task automatic send_beat(input logic [WW-1:0] w, input logic [PW-1:0] p);
        int guard = 0;
        in_valid = 1'b1;
        in_wgt   = w;
        in_prod  = p;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("in_ready_wait", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_beats(input int count, input bit bubbles);
        for (int i = 0; i < count; i++) begin
            send_beat(win_w[i], win_p[i]);
            if (bubbles && i < count - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out_pixel"}, out_pixel, 0);
    endtask

    // Sends the window in win_w/win_p, checks latency, stall behaviour and handshake.
    task automatic run_window(input string name, input longint exp_pix, input bit bubbles, input int stall);
        int cyc = 0;
        logic [OW-1:0] pix;
        send_beats(TAPS, bubbles);
        check({name, "_busy_div"}, busy, 1);
        check({name, "_in_ready_div"}, in_ready, 0);
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        // out_valid appears after the 8th edge following the last accepted beat
        check({name, "_latency"}, cyc, 8);
        pix = out_pixel;
        check({name, "_pixel"}, pix, exp_pix);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({name, "_stall_pixel"}, out_pixel, pix);
            check({name, "_stall_valid"}, out_valid, 1);
            check({name, "_stall_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_post_valid"}, out_valid, 0);
        check({name, "_post_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"uniform100", 1000, 100000, 1000, 100000, 100};
        vecs[1] = '{"round_half", 2, 3, 0, 0, 2};
        vecs[2] = '{"zero_weight", 0, 0, 0, 0, 0};
        vecs[3] = '{"saturate", 1, 1000, 0, 0, 255};

        in_valid  = 1'b0;
        in_prod   = '0;
        in_wgt    = '0;
        out_ready = 1'b0;
        do_reset(3);
        check_idle("reset");

        foreach (vecs[v]) begin
            fill_uniform(vecs[v].w0, vecs[v].p0, vecs[v].wr, vecs[v].pr);
            run_window(vecs[v].name, vecs[v].exp_pix, 1'b0, 0);
        end

        // Bubbles on the input and a five-cycle output stall, then a back-to-back window.
        fill_uniform(1000, 100000, 1000, 100000);
        run_window("bubble_stall", 100, 1'b1, 5);
        run_window("back_to_back", 100, 1'b0, 0);

        // Reset after 60 taps must discard the partial sums.
        send_beats(60, 1'b0);
        do_reset(1);
        check_idle("mid_reset");
        run_window("after_mid_reset", 100, 1'b0, 0);

        // Reset while a result is waiting drops it.
        begin
            int cyc = 0;
            send_beats(TAPS, 1'b0);
            while (!out_valid && cyc < 40) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("out_reset_pre_valid", out_valid, 1);
            do_reset(1);
            check_idle("out_reset");
        end

        // Random windows against the reference model.
        for (int r = 0; r < 8; r++) begin
            int mode = r % 3;
            for (int i = 0; i < TAPS; i++) begin
                int w;
                int pix_i = $urandom_range(0, 255);
                case (mode)
                    0: w = $urandom_range(0, 16383);
                    1: w = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 16383) : 0;
                    default: w = $urandom_range(0, 3);
                endcase
                win_w[i] = WW'(w);
                if (mode == 2) win_p[i] = PW'($urandom_range(0, 4194303));
                else           win_p[i] = PW'(w * pix_i);
            end
            run_window($sformatf("random%0d", r), model_pixel(), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
